grf_wp_arbiter: RTL and testbench
=================================

Name: grf_wp_arbiter

Overview:
- Shares the single GRF write port between the pipeline writeback stage (WB) and the long-latency multiply/divide unit (MDU) result path.
- Contains a 1-entry skid buffer, a starvation counter that raises a pipeline stall request, and a 32-bit pending-write scoreboard.
- Sits between the W-stage/MDU and the GRF; drives the GRF A3/WD/PC inputs. GRF WE stays tied to 1, and A3 == 0 means no write.

Parameters:
- MAX_WAIT, 4, cycles a buffered MDU result may wait before stall_req asserts (1..7).
- WAIT_W, 3, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_valid  in  1  W stage holds a writing instruction
- wb_a3  in  5  W-stage destination register
- wb_wd  in  32  W-stage write data
- wb_pc  in  32  W-stage PC
- mdu_issue  in  1  MDU op with a destination issued this cycle
- mdu_issue_a3  in  5  destination of the issued MDU op
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  arbiter accepts the MDU result this cycle
- mdu_a3  in  5  MDU result destination
- mdu_wd  in  32  MDU result data
- mdu_pc  in  32  PC of the MDU instruction
- rs_a  in  5  D-stage rs index for busy query
- rt_a  in  5  D-stage rt index for busy query
- rs_busy  out  1  rs has a pending MDU write
- rt_busy  out  1  rt has a pending MDU write
- grf_a3  out  5  to GRF A3; 0 means no write
- grf_wd  out  32  to GRF WD
- grf_pc  out  32  to GRF PC
- grf_src  out  2  committing source: NONE/WB/BUF/MDU
- stall_req  out  1  request to hazard unit to bubble the W stage

Behaviour:
- Reset values: buf_valid=0, wait_cnt=0, scoreboard=0. With no traffic, grf_a3=0, grf_wd=0, grf_pc=0, grf_src=NONE, stall_req=0, mdu_ready=1.
- wb_hit = wb_valid && wb_a3!=0. WB is never back-pressured.
- Port select is combinational, zero latency, so the GRF's same-cycle bypass still holds. Priority order:
  - if wb_hit: WB;
  - else if buf_valid: BUF;
  - else if mdu_valid: MDU direct;
  - else NONE, with grf_a3=0.
- mdu_ready = !buf_valid, combinational. Acceptance = mdu_valid && mdu_ready.
  - Accepted with wb_hit=0: written directly this cycle; buffer untouched.
  - Accepted with wb_hit=1: captured into the buffer at the clock edge.
- A buffer drained in cycle N reopens mdu_ready in cycle N+1; no same-cycle refill.
- An MDU result with mdu_a3==0 is accepted and dropped: no write, no buffer capture.
- wait_cnt:
  - increments each cycle buf_valid && wb_hit, saturating at MAX_WAIT;
  - clears to 0 when the buffer drains.
- stall_req = buf_valid && wait_cnt==MAX_WAIT (combinational). Deasserts in the cycle the buffer drains.
- Scoreboard:
  - on mdu_issue && mdu_issue_a3!=0, set bit[mdu_issue_a3];
  - clear the bit of a register when an MDU write to it commits, via BUF or MDU;
  - set and clear of the same register in one cycle: set wins;
  - bit 0 is never set.
- rs_busy/rt_busy are combinational reads of the registered scoreboard.
- WAW between WB and a pending MDU write is prevented externally by the hazard unit using the busy outputs; the arbiter does not check it.
- Reset mid-operation: a buffered result is discarded, the scoreboard clears, and outputs return to reset values asynchronously.

Optional Feature:
- Macro GRF_ARB_TRACE_EN.
- Defined: at each posedge where grf_src is BUF or MDU, $display the time, PC, register and data in the GRF write-trace format. WB writes stay traced only by the GRF.
- Undefined: no display statements are compiled; the logic is identical.

Decomposition:
- Package grf_arb_pkg holds:
  - REG_W=5, DATA_W=32;
  - source encodings SRC_NONE=0, SRC_WB=1, SRC_BUF=2, SRC_MDU=3;
  - default MAX_WAIT.
- Sub-module grf_scoreboard: 32-bit busy vector, set/clear ports, two read ports, set-wins rule.

Test Plan:
- Reset, then idle for 3 cycles → grf_a3=0, mdu_ready=1, stall_req=0, rs_busy=rt_busy=0 throughout.
- Collision: wb_hit writing $5 with 0x11, same cycle as mdu_valid writing $8 with 0x22 → WB commits $5; next cycle with WB idle, BUF commits $8=0x22; mdu_ready low exactly one cycle.
- Starvation: buffer holding $9 while wb_hit for 4 consecutive cycles → stall_req rises in the 5th cycle. W bubbled → BUF commits $9, stall_req and wait_cnt back to 0.
- Scoreboard: mdu_issue $12, rs_a=12 → rs_busy=1 next cycle. MDU commit of $12 → rs_busy=0 the following cycle. mdu_issue $12 in the same cycle as the commit → stays 1.
- Zero destination: mdu_valid with mdu_a3=0 → mdu_ready=1, grf_a3=0, buffer stays empty. mdu_issue_a3=0 → no busy bit set.
- Async reset asserted mid-cycle with the buffer full and busy bits set → buf_valid, wait_cnt and scoreboard clear immediately; no write follows.

Source files
------------

// File: rtl/grf_wp_arbiter_pkg.sv
// Shared types and constants for the GRF write-port arbiter slice.
package grf_arb_pkg;

  localparam int REG_W        = 5;
  localparam int DATA_W       = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W_DEF   = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_MDU  = 2'd3
  } grf_src_e;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } grf_wr_t;

endpackage

// File: rtl/grf_wp_arbiter_if.sv
// Bundle of W-stage, MDU, busy-query and GRF write-port signals around the arbiter.
interface grf_wp_arbiter_if;
  import grf_arb_pkg::*;

  logic              wb_valid;
  logic [REG_W-1:0]  wb_a3;
  logic [DATA_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_pc;
  logic              mdu_issue;
  logic [REG_W-1:0]  mdu_issue_a3;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [REG_W-1:0]  mdu_a3;
  logic [DATA_W-1:0] mdu_wd;
  logic [DATA_W-1:0] mdu_pc;
  logic [REG_W-1:0]  rs_a;
  logic [REG_W-1:0]  rt_a;
  logic              rs_busy;
  logic              rt_busy;
  logic [REG_W-1:0]  grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] grf_pc;
  grf_src_e          grf_src;
  logic              stall_req;

  modport master (
    output wb_valid, wb_a3, wb_wd, wb_pc,
    output mdu_issue, mdu_issue_a3, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    output rs_a, rt_a,
    input  mdu_ready, rs_busy, rt_busy,
    input  grf_a3, grf_wd, grf_pc, grf_src, stall_req
  );

  modport slave (
    input  wb_valid, wb_a3, wb_wd, wb_pc,
    input  mdu_issue, mdu_issue_a3, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    input  rs_a, rt_a,
    output mdu_ready, rs_busy, rt_busy,
    output grf_a3, grf_wd, grf_pc, grf_src, stall_req
  );

endinterface

// File: rtl/grf_wp_arbiter_scoreboard.sv
// Pending-MDU-write busy vector: one bit per GRF register, set beats clear, $0 never busy.
module grf_scoreboard
  import grf_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_a,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_a,
  input  logic [REG_W-1:0] rd0_a,
  input  logic [REG_W-1:0] rd1_a,
  output logic             rd0_busy,
  output logic             rd1_busy
);

  localparam int NREG = 1 << REG_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        assign busy_d[gi] = (set_en && set_a == REG_W'(gi)) ||
                            (busy_q[gi] && !(clr_en && clr_a == REG_W'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rd0_busy = busy_q[rd0_a];
  assign rd1_busy = busy_q[rd1_a];

endmodule

// File: rtl/grf_wp_arbiter.sv
// Shares the GRF write port between W-stage writeback and the MDU result path.
// Optional macro GRF_ARB_TRACE_EN: trace BUF/MDU commits in GRF write-trace format.
module grf_wp_arbiter
  import grf_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = WAIT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  grf_wp_arbiter_if.slave      bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic              wb_hit;
  logic              mdu_live;
  logic              buf_capture;
  logic              buf_drain;
  logic              buf_valid_q, buf_valid_d;
  grf_wr_t           buf_q, buf_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  grf_src_e          src;

  assign wb_hit      = bus.wb_valid && (bus.wb_a3 != '0);
  // Zero-destination MDU results are accepted but never written or buffered.
  assign mdu_live    = bus.mdu_valid && !buf_valid_q && (bus.mdu_a3 != '0);
  assign buf_capture = mdu_live && wb_hit;
  assign buf_drain   = buf_valid_q && !wb_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      wait_cnt_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    wait_cnt_d  = wait_cnt_q;
    if (buf_drain) begin
      buf_valid_d = 1'b0;
      wait_cnt_d  = '0;
    end else if (buf_valid_q && wb_hit && wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    // Capture only happens with the buffer empty, so it never overlaps a drain.
    if (buf_capture) begin
      buf_valid_d = 1'b1;
      buf_d       = '{a3: bus.mdu_a3, wd: bus.mdu_wd, pc: bus.mdu_pc};
    end
  end

  always_comb begin
    src        = SRC_NONE;
    bus.grf_a3 = '0;
    bus.grf_wd = '0;
    bus.grf_pc = '0;
    if (wb_hit) begin
      src        = SRC_WB;
      bus.grf_a3 = bus.wb_a3;
      bus.grf_wd = bus.wb_wd;
      bus.grf_pc = bus.wb_pc;
    end else if (buf_valid_q) begin
      src        = SRC_BUF;
      bus.grf_a3 = buf_q.a3;
      bus.grf_wd = buf_q.wd;
      bus.grf_pc = buf_q.pc;
    end else if (mdu_live) begin
      src        = SRC_MDU;
      bus.grf_a3 = bus.mdu_a3;
      bus.grf_wd = bus.mdu_wd;
      bus.grf_pc = bus.mdu_pc;
    end
  end

  assign bus.grf_src   = src;
  assign bus.mdu_ready = !buf_valid_q;
  assign bus.stall_req = buf_valid_q && (wait_cnt_q == MAX_WAIT_C);

  grf_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.mdu_issue && bus.mdu_issue_a3 != '0),
    .set_a    (bus.mdu_issue_a3),
    .clr_en   (src == SRC_BUF || src == SRC_MDU),
    .clr_a    (src == SRC_BUF ? buf_q.a3 : bus.mdu_a3),
    .rd0_a    (bus.rs_a),
    .rd1_a    (bus.rt_a),
    .rd0_busy (bus.rs_busy),
    .rd1_busy (bus.rt_busy)
  );

`ifdef GRF_ARB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && (src == SRC_BUF || src == SRC_MDU)) begin
      $display("%0t@%h: $%d <= %h", $time, bus.grf_pc, bus.grf_a3, bus.grf_wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_grf_wp_arbiter.sv
// Directed self-checking bench for grf_wp_arbiter: collision, starvation, scoreboard, zero dest, async reset.
module tb_grf_wp_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  grf_wp_arbiter_if bus ();

  grf_wp_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    bus.wb_valid = 0; bus.wb_a3 = 0; bus.wb_wd = 0; bus.wb_pc = 0;
    bus.mdu_issue = 0; bus.mdu_issue_a3 = 0;
    bus.mdu_valid = 0; bus.mdu_a3 = 0; bus.mdu_wd = 0; bus.mdu_pc = 0;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic show(input string tag);
    $display("[%s] t=%0t src=%0d a3=%0d wd=%h pc=%h rdy=%0b stall=%0b rs_busy=%0b rt_busy=%0b",
             tag, $time, bus.grf_src, bus.grf_a3, bus.grf_wd, bus.grf_pc,
             bus.mdu_ready, bus.stall_req, bus.rs_busy, bus.rt_busy);
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.rs_a = 5'd3; bus.rt_a = 5'd7;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      show("idle");
      checks++; if (bus.grf_a3 !== 5'd0) $display("FAIL reset_a3 got %0d want 0", bus.grf_a3); else passed++;
      checks++; if (bus.grf_wd !== 32'd0) $display("FAIL reset_wd got %h want 0", bus.grf_wd); else passed++;
      checks++; if (bus.grf_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", bus.grf_pc); else passed++;
      checks++; if (bus.grf_src !== 2'd0) $display("FAIL reset_src got %0d want 0", bus.grf_src); else passed++;
      checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", bus.mdu_ready); else passed++;
      checks++; if (bus.stall_req !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.stall_req); else passed++;
      checks++; if ({bus.rs_busy, bus.rt_busy} !== 2'b00) $display("FAIL reset_busy got %b want 00", {bus.rs_busy, bus.rt_busy}); else passed++;
      next_cycle();
    end
  endtask

  task automatic test_collision;
    bus.rs_a = 5'd8;
    bus.mdu_issue = 1; bus.mdu_issue_a3 = 5'd8;
    next_cycle();
    bus.mdu_issue = 0; bus.mdu_issue_a3 = 0;
    bus.wb_valid = 1; bus.wb_a3 = 5'd5; bus.wb_wd = 32'h11; bus.wb_pc = 32'h3000;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd8; bus.mdu_wd = 32'h22; bus.mdu_pc = 32'h3004;
    @(negedge clk);
    show("coll");
    checks++; if (bus.grf_src !== 2'd1) $display("FAIL coll_src got %0d want 1", bus.grf_src); else passed++;
    checks++; if (bus.grf_a3 !== 5'd5) $display("FAIL coll_a3 got %0d want 5", bus.grf_a3); else passed++;
    checks++; if (bus.grf_wd !== 32'h11) $display("FAIL coll_wd got %h want 11", bus.grf_wd); else passed++;
    checks++; if (bus.grf_pc !== 32'h3000) $display("FAIL coll_pc got %h want 3000", bus.grf_pc); else passed++;
    checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL coll_ready0 got %0b want 1", bus.mdu_ready); else passed++;
    checks++; if (bus.rs_busy !== 1'b1) $display("FAIL coll_busy0 got %0b want 1", bus.rs_busy); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    show("drain");
    checks++; if (bus.grf_src !== 2'd2) $display("FAIL drain_src got %0d want 2", bus.grf_src); else passed++;
    checks++; if (bus.grf_a3 !== 5'd8) $display("FAIL drain_a3 got %0d want 8", bus.grf_a3); else passed++;
    checks++; if (bus.grf_wd !== 32'h22) $display("FAIL drain_wd got %h want 22", bus.grf_wd); else passed++;
    checks++; if (bus.grf_pc !== 32'h3004) $display("FAIL drain_pc got %h want 3004", bus.grf_pc); else passed++;
    checks++; if (bus.mdu_ready !== 1'b0) $display("FAIL drain_ready got %0b want 0", bus.mdu_ready); else passed++;
    checks++; if (bus.rs_busy !== 1'b1) $display("FAIL drain_busy got %0b want 1", bus.rs_busy); else passed++;
    next_cycle();
    @(negedge clk);
    show("after");
    checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL after_ready got %0b want 1", bus.mdu_ready); else passed++;
    checks++; if (bus.grf_src !== 2'd0) $display("FAIL after_src got %0d want 0", bus.grf_src); else passed++;
    checks++; if (bus.rs_busy !== 1'b0) $display("FAIL after_busy got %0b want 0", bus.rs_busy); else passed++;
    next_cycle();
  endtask

  task automatic test_starvation;
    bus.wb_valid = 1; bus.wb_a3 = 5'd1; bus.wb_wd = 32'hA0; bus.wb_pc = 32'h4000;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd9; bus.mdu_wd = 32'h99; bus.mdu_pc = 32'h4100;
    next_cycle();
    bus.mdu_valid = 0; bus.mdu_a3 = 0;
    for (int i = 1; i <= 4; i++) begin
      bus.wb_a3 = 5'(i + 1); bus.wb_wd = 32'hA0 + 32'(i);
      @(negedge clk);
      show("starve");
      checks++; if (bus.stall_req !== 1'b0) $display("FAIL starve_stall%0d got %0b want 0", i, bus.stall_req); else passed++;
      checks++; if (bus.grf_src !== 2'd1) $display("FAIL starve_src%0d got %0d want 1", i, bus.grf_src); else passed++;
      next_cycle();
    end
    @(negedge clk);
    show("stall");
    checks++; if (bus.stall_req !== 1'b1) $display("FAIL stall_rise got %0b want 1", bus.stall_req); else passed++;
    checks++; if (bus.mdu_ready !== 1'b0) $display("FAIL stall_ready got %0b want 0", bus.mdu_ready); else passed++;
    next_cycle();
    bus.wb_valid = 0; bus.wb_a3 = 0;
    @(negedge clk);
    show("bubble");
    checks++; if (bus.grf_src !== 2'd2) $display("FAIL bubble_src got %0d want 2", bus.grf_src); else passed++;
    checks++; if (bus.grf_a3 !== 5'd9) $display("FAIL bubble_a3 got %0d want 9", bus.grf_a3); else passed++;
    checks++; if (bus.grf_wd !== 32'h99) $display("FAIL bubble_wd got %h want 99", bus.grf_wd); else passed++;
    next_cycle();
    @(negedge clk);
    show("post");
    checks++; if (bus.stall_req !== 1'b0) $display("FAIL post_stall got %0b want 0", bus.stall_req); else passed++;
    checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL post_ready got %0b want 1", bus.mdu_ready); else passed++;
    // Refill and one WB hit: a stale counter would raise stall_req immediately.
    bus.wb_valid = 1; bus.wb_a3 = 5'd2; bus.mdu_valid = 1; bus.mdu_a3 = 5'd10; bus.mdu_wd = 32'h10;
    next_cycle();
    bus.mdu_valid = 0; bus.mdu_a3 = 0;
    @(negedge clk);
    show("refill");
    checks++; if (bus.stall_req !== 1'b0) $display("FAIL refill_stall got %0b want 0", bus.stall_req); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    show("redrain");
    checks++; if (bus.grf_a3 !== 5'd10) $display("FAIL redrain_a3 got %0d want 10", bus.grf_a3); else passed++;
    next_cycle();
  endtask

  task automatic test_scoreboard;
    bus.rs_a = 5'd12; bus.rt_a = 5'd13;
    bus.mdu_issue = 1; bus.mdu_issue_a3 = 5'd12;
    @(negedge clk);
    show("issue");
    checks++; if (bus.rs_busy !== 1'b0) $display("FAIL sb_pre got %0b want 0", bus.rs_busy); else passed++;
    next_cycle();
    bus.mdu_issue = 0; bus.mdu_issue_a3 = 0;
    @(negedge clk);
    show("busy");
    checks++; if (bus.rs_busy !== 1'b1) $display("FAIL sb_set got %0b want 1", bus.rs_busy); else passed++;
    checks++; if (bus.rt_busy !== 1'b0) $display("FAIL sb_rt got %0b want 0", bus.rt_busy); else passed++;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd12; bus.mdu_wd = 32'h1234; bus.mdu_pc = 32'h5000;
    @(negedge clk);
    show("direct");
    checks++; if (bus.grf_src !== 2'd3) $display("FAIL sb_direct_src got %0d want 3", bus.grf_src); else passed++;
    checks++; if (bus.grf_wd !== 32'h1234) $display("FAIL sb_direct_wd got %h want 1234", bus.grf_wd); else passed++;
    next_cycle();
    bus.mdu_valid = 0; bus.mdu_a3 = 0;
    @(negedge clk);
    show("clear");
    checks++; if (bus.rs_busy !== 1'b0) $display("FAIL sb_clear got %0b want 0", bus.rs_busy); else passed++;
    bus.mdu_issue = 1; bus.mdu_issue_a3 = 5'd12;
    next_cycle();
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd12; bus.mdu_wd = 32'h5678;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    show("setwins");
    checks++; if (bus.rs_busy !== 1'b1) $display("FAIL sb_setwins got %0b want 1", bus.rs_busy); else passed++;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd12;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_zero_dest;
    bus.rs_a = 5'd0; bus.rt_a = 5'd7;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd0; bus.mdu_wd = 32'hDEAD;
    bus.mdu_issue = 1; bus.mdu_issue_a3 = 5'd0;
    @(negedge clk);
    show("zero");
    checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL zero_ready got %0b want 1", bus.mdu_ready); else passed++;
    checks++; if (bus.grf_a3 !== 5'd0) $display("FAIL zero_a3 got %0d want 0", bus.grf_a3); else passed++;
    checks++; if (bus.grf_src !== 2'd0) $display("FAIL zero_src got %0d want 0", bus.grf_src); else passed++;
    bus.wb_valid = 1; bus.wb_a3 = 5'd4; bus.wb_wd = 32'h44;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    show("zeronobuf");
    checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL zero_nobuf_ready got %0b want 1", bus.mdu_ready); else passed++;
    checks++; if (bus.grf_src !== 2'd0) $display("FAIL zero_nobuf_src got %0d want 0", bus.grf_src); else passed++;
    checks++; if (bus.rs_busy !== 1'b0) $display("FAIL zero_busy got %0b want 0", bus.rs_busy); else passed++;
    bus.wb_valid = 1; bus.wb_a3 = 5'd0; bus.wb_wd = 32'hBAD;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd7; bus.mdu_wd = 32'h77;
    @(negedge clk);
    show("wbzero");
    checks++; if (bus.grf_src !== 2'd3) $display("FAIL wbzero_src got %0d want 3", bus.grf_src); else passed++;
    checks++; if (bus.grf_wd !== 32'h77) $display("FAIL wbzero_wd got %h want 77", bus.grf_wd); else passed++;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_async_reset;
    bus.rs_a = 5'd20; bus.rt_a = 5'd21;
    bus.mdu_issue = 1; bus.mdu_issue_a3 = 5'd20;
    next_cycle();
    bus.mdu_issue_a3 = 5'd21;
    bus.wb_valid = 1; bus.wb_a3 = 5'd3; bus.wb_wd = 32'h33;
    bus.mdu_valid = 1; bus.mdu_a3 = 5'd20; bus.mdu_wd = 32'h2020;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    show("prereset");
    checks++; if ({bus.rs_busy, bus.rt_busy} !== 2'b11) $display("FAIL ar_pre_busy got %b want 11", {bus.rs_busy, bus.rt_busy}); else passed++;
    checks++; if (bus.grf_src !== 2'd2) $display("FAIL ar_pre_src got %0d want 2", bus.grf_src); else passed++;
    #2 reset = 1'b1;
    #1;
    show("inreset");
    checks++; if ({bus.rs_busy, bus.rt_busy} !== 2'b00) $display("FAIL ar_busy got %b want 00", {bus.rs_busy, bus.rt_busy}); else passed++;
    checks++; if (bus.mdu_ready !== 1'b1) $display("FAIL ar_ready got %0b want 1", bus.mdu_ready); else passed++;
    checks++; if (bus.grf_a3 !== 5'd0) $display("FAIL ar_a3 got %0d want 0", bus.grf_a3); else passed++;
    checks++; if (bus.stall_req !== 1'b0) $display("FAIL ar_stall got %0b want 0", bus.stall_req); else passed++;
    next_cycle();
    #3 reset = 1'b0;
    @(negedge clk);
    show("postreset");
    checks++; if (bus.grf_src !== 2'd0) $display("FAIL ar_post_src got %0d want 0", bus.grf_src); else passed++;
    checks++; if (bus.rs_busy !== 1'b0) $display("FAIL ar_post_busy got %0b want 0", bus.rs_busy); else passed++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_collision();
    test_starvation();
    test_scoreboard();
    test_zero_dest();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
